softmax_mode1_reader: RTL and testbench

Streaming front end for the softmax mode-1 max-reduction stage: on `start` it reads a vector of `inp_len` FP elements from the input buffer, four per word, and presents them on four lanes with a run strobe, one word per cycle. It clears the max accumulator before the first beat, pads a partial last word with −∞, and pulses `mode1_done` once the accumulator holds the final max. It sits between the input SRAM and the 4-lane max tree, and is the producer end of that tree's `inp0..inp3` / `mode1_run` interface.

---
 rtl/softmax_mode1_reader_pkg.sv | 26 ++
 rtl/softmax_mode1_reader_if.sv | 31 +++
 rtl/softmax_mode1_reader_lane_pad.sv | 28 ++
 rtl/softmax_mode1_reader.sv | 128 ++++++++++++
 tb/tb_softmax_mode1_reader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/softmax_mode1_reader_pkg.sv
// Shared constants and types for the softmax mode-1 reader.
// FP format mirrors defines.v; MODE1_READER_TAILPAD_EN enables tail padding.
package softmax_mode1_reader_pkg;

    localparam int DATAWIDTH  = 16;
    localparam int MANTISSA   = 10;
    localparam int EXPONENT   = 5;
    localparam int ADDR_WIDTH = 10;
    localparam int LEN_WIDTH  = 12;
    localparam int LANES      = 4;

    localparam logic [DATAWIDTH-1:0] FP_NEG_INF =
        {1'b1, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};

    typedef logic [DATAWIDTH-1:0]             fp_t;
    typedef logic [LANES*DATAWIDTH-1:0]       word_t;
    typedef logic [LANES-1:0][DATAWIDTH-1:0]  lanes_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/softmax_mode1_reader_if.sv
// Input-buffer read port plus the lane/strobe bundle to the 4-lane max tree.
// master = reader side, slave = SRAM + max tree side.
interface softmax_mode1_reader_if;
    import softmax_mode1_reader_pkg::*;

    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_addr;
    word_t                 mem_rdata;
    fp_t                   outp0;
    fp_t                   outp1;
    fp_t                   outp2;
    fp_t                   outp3;
    logic                  mode1_run;
    logic                  mode1_clr;
    logic                  mode1_done;

    modport master (
        output mem_ren, mem_addr,
        output outp0, outp1, outp2, outp3,
        output mode1_run, mode1_clr, mode1_done,
        input  mem_rdata
    );

    modport slave (
        input  mem_ren, mem_addr,
        input  outp0, outp1, outp2, outp3,
        input  mode1_run, mode1_clr, mode1_done,
        output mem_rdata
    );

endinterface

// File: rtl/softmax_mode1_reader_lane_pad.sv
// mode1_lane_pad: splits a buffer word into lanes, forcing -inf past the
// vector end in the last word. Built only with MODE1_READER_TAILPAD_EN.
`ifdef MODE1_READER_TAILPAD_EN
module mode1_lane_pad
    import softmax_mode1_reader_pkg::*;
(
    input  word_t      i_word,
    input  logic       i_vld,
    input  logic       i_last,
    input  logic [1:0] i_len_lo,
    output lanes_t     o_lanes
);

    always_comb begin
        o_lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            if (i_vld) begin
                if (i_last && (i_len_lo != 2'd0) &&
                    (k >= int'(i_len_lo)))
                    o_lanes[k] = FP_NEG_INF;
                else
                    o_lanes[k] = i_word[k*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

endmodule
`endif

// File: rtl/softmax_mode1_reader.sv
// Streams an FP vector from the input buffer onto the 4-lane max tree.
// Define MODE1_READER_TAILPAD_EN for ceil() word count and -inf tail padding.
module softmax_mode1_reader
    import softmax_mode1_reader_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_inp_len,
    output logic                  o_busy,
    softmax_mode1_reader_if.master bus
);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_words;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [LEN_WIDTH-1:0]  w_words;
    logic                  r_vld;
    logic                  r_clr;
    logic                  w_accept;
    logic                  w_last_issue;
    lanes_t                w_lanes;

`ifdef MODE1_READER_TAILPAD_EN
    logic [LEN_WIDTH:0] w_len_up;
    logic               r_last;
    logic [1:0]         r_len_lo;

    assign w_len_up = {1'b0, i_inp_len} + (LEN_WIDTH+1)'(3);
    assign w_words  = LEN_WIDTH'(w_len_up >> 2);
`else
    assign w_words  = i_inp_len >> 2;
`endif

    assign w_accept     = (r_state == ST_IDLE) && i_start;
    assign w_last_issue = (r_cnt + LEN_WIDTH'(1)) == r_words;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        bus.mem_ren    = 1'b0;
        bus.mode1_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start)
                    w_next = (w_words == '0) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                bus.mem_ren = 1'b1;
                if (w_last_issue)
                    w_next = ST_DRAIN;
            end
            // last beat is on the lanes this cycle
            ST_DRAIN: begin
                if (r_vld)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                bus.mode1_done = 1'b1;
                w_next         = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_words <= '0;
            r_vld   <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_clr <= w_accept;
            r_vld <= bus.mem_ren;
            if (w_accept) begin
                r_addr  <= i_base_addr;
                r_cnt   <= '0;
                r_words <= w_words;
            end else if (bus.mem_ren) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                r_cnt  <= r_cnt + LEN_WIDTH'(1);
            end
        end
    end

`ifdef MODE1_READER_TAILPAD_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last   <= 1'b0;
            r_len_lo <= 2'd0;
        end else begin
            r_last <= bus.mem_ren && w_last_issue;
            if (w_accept)
                r_len_lo <= i_inp_len[1:0];
        end
    end

    mode1_lane_pad u_pad (
        .i_word   (bus.mem_rdata),
        .i_vld    (r_vld),
        .i_last   (r_last),
        .i_len_lo (r_len_lo),
        .o_lanes  (w_lanes)
    );
`else
    assign w_lanes = r_vld ? bus.mem_rdata : '0;
`endif

    assign bus.mem_addr  = r_addr;
    assign bus.outp0     = w_lanes[0];
    assign bus.outp1     = w_lanes[1];
    assign bus.outp2     = w_lanes[2];
    assign bus.outp3     = w_lanes[3];
    assign bus.mode1_run = r_vld;
    assign bus.mode1_clr = r_clr;
    assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_softmax_mode1_reader.sv
// Self-checking bench for softmax_mode1_reader: directed table, random runs,
// restart-while-busy and mid-run reset sequences against a behavioural model.
module tb_softmax_mode1_reader;
    import softmax_mode1_reader_pkg::*;

    localparam int MEMW = 1 << ADDR_WIDTH;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] base_addr = '0;
    logic [LEN_WIDTH-1:0]  inp_len = '0;
    logic                  busy;

    softmax_mode1_reader_if bus();

    softmax_mode1_reader dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_inp_len   (inp_len),
        .o_busy      (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    word_t mem [0:MEMW-1];

    always @(posedge clk)
        if (bus.mem_ren)
            bus.mem_rdata <= mem[bus.mem_addr];

    // FP16 ordering key: larger key means larger value (no NaNs used)
    function automatic logic [15:0] fkey(fp_t v);
        return v[15] ? ~v : (v | 16'h8000);
    endfunction

    function automatic fp_t fmax(fp_t a, fp_t b);
        return (fkey(a) >= fkey(b)) ? a : b;
    endfunction

    // downstream max accumulator as the max tree would hold it
    fp_t acc;
    always @(posedge clk) begin
        if (bus.mode1_clr)
            acc <= FP_NEG_INF;
        else if (bus.mode1_run)
            acc <= fmax(fmax(acc, bus.outp0),
                        fmax(fmax(bus.outp1, bus.outp2), bus.outp3));
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, int t, logic [63:0] act,
                       logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h required=%0h",
                     name, t, act, exp);
        end
    endtask

    function automatic int words_of(int len);
`ifdef MODE1_READER_TAILPAD_EN
        return (len + 3) / 4;
`else
        return len / 4;
`endif
    endfunction

    function automatic fp_t exp_lane(int base, int len, int j, int k);
        word_t w;
        fp_t   v;
        w = mem[(base + j) % MEMW];
        v = w[k*DATAWIDTH +: DATAWIDTH];
`ifdef MODE1_READER_TAILPAD_EN
        if (j * 4 + k >= len)
            v = FP_NEG_INF;
`endif
        return v;
    endfunction

    function automatic fp_t exp_max(int base, int len);
        fp_t m;
        m = FP_NEG_INF;
        for (int j = 0; j < words_of(len); j++)
            for (int k = 0; k < 4; k++)
                m = fmax(m, exp_lane(base, len, j, k));
        return m;
    endfunction

    function automatic fp_t fp_int(int n);
        case (n)
            1: return 16'h3C00;
            2: return 16'h4000;
            3: return 16'h4200;
            4: return 16'h4400;
            5: return 16'h4500;
            6: return 16'h4600;
            7: return 16'h4700;
            default: return 16'h4800;
        endcase
    endfunction

    // elements 1..len (negated when neg), garbage 7BFF elsewhere
    task automatic fill_pat(int base, int len, bit neg);
        word_t w;
        for (int j = 0; j < 4; j++) begin
            w = {4{16'h7BFF}};
            for (int k = 0; k < 4; k++)
                if (j * 4 + k < len)
                    w[k*16 +: 16] = fp_int(j*4 + k + 1) | {neg, 15'd0};
            mem[(base + j) % MEMW] = w;
        end
    endtask

    function automatic fp_t rnd_fp();
        fp_t v;
        v[15]    = 1'($urandom_range(0, 1));
        v[14:10] = 5'($urandom_range(0, 30));
        v[9:0]   = 10'($urandom_range(0, 1023));
        return v;
    endfunction

    task automatic fill_rnd(int base, int nwords);
        word_t w;
        for (int j = 0; j < nwords; j++) begin
            for (int k = 0; k < 4; k++)
                w[k*16 +: 16] = rnd_fp();
            mem[(base + j) % MEMW] = w;
        end
    endtask

    task automatic check_cycle(int base, int len, int t);
        int  W;
        bit  ren_e, run_e;
        fp_t lo [4];
        W     = words_of(len);
        ren_e = (t >= 1) && (t <= W);
        run_e = (t >= 2) && (t <= W + 1);
        lo[0] = bus.outp0;
        lo[1] = bus.outp1;
        lo[2] = bus.outp2;
        lo[3] = bus.outp3;
        chk("mem_ren", t, 64'(bus.mem_ren), 64'(ren_e));
        if (ren_e)
            chk("mem_addr", t, 64'(bus.mem_addr),
                64'((base + t - 1) % MEMW));
        chk("mode1_run", t, 64'(bus.mode1_run), 64'(run_e));
        for (int k = 0; k < 4; k++)
            chk($sformatf("lane%0d", k), t, 64'(lo[k]),
                run_e ? 64'(exp_lane(base, len, t - 2, k)) : 64'd0);
        chk("mode1_clr", t, 64'(bus.mode1_clr), 64'(t == 1));
        chk("mode1_done", t, 64'(bus.mode1_done),
            64'((W == 0) ? (t == 1) : (t == W + 2)));
        chk("busy", t, 64'(busy),
            64'((W == 0) ? (t == 1) : (t >= 1 && t <= W + 2)));
    endtask

    task automatic run_vec(int base, int len, int ew, fp_t em,
                           int restart_t);
        int W;
        int nren;
        int ndone;
        W     = words_of(len);
        nren  = 0;
        ndone = 0;
        @(negedge clk);
        base_addr = ADDR_WIDTH'(base);
        inp_len   = LEN_WIDTH'(len);
        start     = 1'b1;
        for (int t = 1; t <= W + 4; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (t == restart_t) begin
                start     = 1'b1;
                base_addr = ADDR_WIDTH'(base + 77);
                inp_len   = LEN_WIDTH'(len + 8);
            end
            check_cycle(base, len, t);
            nren  += int'(bus.mem_ren);
            ndone += int'(bus.mode1_done);
        end
        start = 1'b0;
        chk("read_words", len, 64'(nren), 64'(ew));
        chk("done_count", len, 64'(ndone), 64'd1);
        chk("max", len, 64'(acc), 64'(em));
    endtask

    typedef struct {
        int  base;
        int  len;
        bit  neg;
        int  ew;
        fp_t em;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{5,    8, 1'b0, 2, 16'h4800};
        vecs[2] = '{0,    0, 1'b0, 0, 16'hFC00};
        vecs[3] = '{1023, 8, 1'b0, 2, 16'h4800};
`ifdef MODE1_READER_TAILPAD_EN
        vecs[1] = '{40,   6, 1'b1, 2, 16'hBC00};
        vecs[4] = '{10,   3, 1'b0, 1, 16'h4200};
        vecs[5] = '{200,  5, 1'b1, 2, 16'hBC00};
`else
        vecs[1] = '{40,   6, 1'b1, 1, 16'hBC00};
        vecs[4] = '{10,   3, 1'b0, 0, 16'hFC00};
        vecs[5] = '{200,  5, 1'b1, 1, 16'hBC00};
`endif
        for (int i = 0; i < MEMW; i++)
            mem[i] = {4{16'h7BFF}};

        repeat (3) @(negedge clk);
        chk("rst_ren", 0, 64'(bus.mem_ren), 64'd0);
        chk("rst_addr", 0, 64'(bus.mem_addr), 64'd0);
        chk("rst_lanes", 0,
            64'({bus.outp0, bus.outp1, bus.outp2, bus.outp3}), 64'd0);
        chk("rst_ctl", 0, 64'({bus.mode1_run, bus.mode1_clr,
                               bus.mode1_done, busy}), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            fill_pat(vecs[i].base, vecs[i].len, vecs[i].neg);
            run_vec(vecs[i].base, vecs[i].len, vecs[i].ew,
                    vecs[i].em, 0);
        end

        // second start while busy must be ignored
        fill_rnd(300, 10);
        run_vec(300, 32, 8, exp_max(300, 32), 2);

        // reset in the middle of a 16-word run
        fill_rnd(500, 18);
        @(negedge clk);
        base_addr = 10'd500;
        inp_len   = 12'd64;
        start     = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            start = 1'b0;
            check_cycle(500, 64, t);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_ren", 4, 64'(bus.mem_ren), 64'd0);
        chk("rst_mid_addr", 4, 64'(bus.mem_addr), 64'd0);
        chk("rst_mid_lanes", 4,
            64'({bus.outp0, bus.outp1, bus.outp2, bus.outp3}), 64'd0);
        chk("rst_mid_ctl", 4, 64'({bus.mode1_run, bus.mode1_clr,
                                   bus.mode1_done, busy}), 64'd0);
        for (int t = 5; t <= 20; t++) begin
            @(negedge clk);
            chk("rst_no_done", t, 64'(bus.mode1_done), 64'd0);
            chk("rst_no_ren", t, 64'(bus.mem_ren), 64'd0);
        end
        run_vec(500, 64, 16, exp_max(500, 64), 0);

        // randomized runs against the model
        for (int i = 0; i < 24; i++) begin
            int b;
            int l;
            b = int'($urandom_range(0, MEMW - 1));
            l = int'($urandom_range(0, 40));
            fill_rnd(b, 11);
            run_vec(b, l, words_of(l), exp_max(b, l), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
